// File: rtl/pipe_ctrl_defs_pkg.sv
// Shared encodings and control bundle for the pipeline hazard sequencer.
// Holds FSM state codes, the zero register and default timing limits.
package pipe_ctrl_defs_pkg;

  localparam logic [1:0] ST_DRAIN    = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int DEF_DRAIN_CYCLES = 4;
  localparam int DEF_MAX_WAIT     = 16;

  typedef struct packed {
    logic pcWrite;
    logic ifidWrite;
    logic idexWrite;
    logic exmemWrite;
    logic memwbWrite;
    logic ifidFlush;
    logic idexFlush;
    logic exmemFlush;
    logic memwbFlush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_DRAIN  = 9'b0_0000_1111;
  localparam pipe_ctrl_t CTRL_RUN    = 9'b1_1111_0000;
  localparam pipe_ctrl_t CTRL_FREEZE = 9'b0_0001_0001;
  localparam pipe_ctrl_t CTRL_BRANCH = 9'b1_1111_1100;
  localparam pipe_ctrl_t CTRL_JUMP   = 9'b1_1111_1000;
  localparam pipe_ctrl_t CTRL_LDUSE  = 9'b0_0111_0100;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare between ID/EX load and IF/ID consumer.
// Register zero never produces a stall.
module hazard_detect
  import pipe_ctrl_defs_pkg::*;
(
  input  logic       idexMemRead,
  input  logic [4:0] idexRt,
  input  logic [4:0] ifidRs,
  input  logic [4:0] ifidRt,
  input  logic       ifidUsesRt,
  output logic       stall
);

  logic rsHit;
  logic rtHit;

  assign rsHit = (idexRt == ifidRs);
  assign rtHit = ifidUsesRt && (idexRt == ifidRt);

  assign stall = idexMemRead
              && (idexRt != REG_ZERO)
              && (rsHit || rtHit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register / PC sequencer: drain, stall, flush and memory freeze.
// Optional statistics counters enabled by HAZ_STATS_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_defs_pkg::*;
#(
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int MAX_WAIT     = DEF_MAX_WAIT,
  parameter int CNT_W        = 5
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        inIDEXMemRead,
  input  logic [4:0]  inIDEXRt,
  input  logic [4:0]  inIFIDRs,
  input  logic [4:0]  inIFIDRt,
  input  logic        inIFIDUsesRt,
  input  logic        inBranchTaken,
  input  logic        inJump,
  input  logic        inMemReq,
  input  logic        inMemReady,
  output logic        outPCWrite,
  output logic        outIFIDWrite,
  output logic        outIDEXWrite,
  output logic        outEXMEMWrite,
  output logic        outMEMWBWrite,
  output logic        outIFIDFlush,
  output logic        outIDEXFlush,
  output logic        outEXMEMFlush,
  output logic        outMEMWBFlush,
  output logic        outMemTimeout,
  output logic [1:0]  outState,
  output logic [31:0] outStallCount,
  output logic [31:0] outFlushCount,
  output logic [31:0] outWaitCount
);

  logic [1:0]       state;
  logic [1:0]       nextState;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nextCnt;
  logic [CNT_W-1:0] cntInc;
  logic             timeout;
  pipe_ctrl_t       ctrl;
  logic             loadUse;
  logic             drainNow;
  logic             memBusy;
  logic             selBr;
  logic             selJmp;
  logic             selLu;
  logic             isStall;
  logic             isFlush;
  logic             isFreeze;

  hazard_detect uDetect (
    .idexMemRead (inIDEXMemRead),
    .idexRt      (inIDEXRt),
    .ifidRs      (inIFIDRs),
    .ifidRt      (inIFIDRt),
    .ifidUsesRt  (inIFIDUsesRt),
    .stall       (loadUse)
  );

  // Unknown encodings fall back to the drain behaviour.
  assign drainNow = Reset
                 || ((state != ST_RUN) && (state != ST_MEM_WAIT));
  assign memBusy  = !inMemReady
                 && ((state == ST_MEM_WAIT) || inMemReq);
  assign cntInc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  assign selBr  = inBranchTaken;
  assign selJmp = inJump && !inBranchTaken;
  assign selLu  = loadUse && !inJump && !inBranchTaken;

  always_comb begin
    ctrl      = CTRL_RUN;
    nextState = state;
    nextCnt   = cnt;
    isStall   = 1'b0;
    isFlush   = 1'b0;
    isFreeze  = 1'b0;
    if (drainNow) begin
      ctrl = CTRL_DRAIN;
      if (cnt >= CNT_W'(DRAIN_CYCLES - 1)) begin
        nextState = ST_RUN;
        nextCnt   = '0;
      end else begin
        nextState = ST_DRAIN;
        nextCnt   = cntInc;
      end
    end else if (memBusy) begin
      ctrl      = CTRL_FREEZE;
      isFreeze  = 1'b1;
      nextState = ST_MEM_WAIT;
      nextCnt   = (state == ST_RUN) ? CNT_W'(1) : cntInc;
    end else begin
      nextState = ST_RUN;
      nextCnt   = '0;
      unique case (1'b1)
        selBr: begin
          ctrl    = CTRL_BRANCH;
          isFlush = 1'b1;
        end
        selJmp: begin
          ctrl    = CTRL_JUMP;
          isFlush = 1'b1;
        end
        selLu: begin
          ctrl    = CTRL_LDUSE;
          isStall = 1'b1;
        end
        default: ctrl = CTRL_RUN;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= ST_DRAIN;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
      if (isFreeze && (nextCnt == CNT_W'(MAX_WAIT)))
        timeout <= 1'b1;
    end
  end

  assign outPCWrite    = ctrl.pcWrite;
  assign outIFIDWrite  = ctrl.ifidWrite;
  assign outIDEXWrite  = ctrl.idexWrite;
  assign outEXMEMWrite = ctrl.exmemWrite;
  assign outMEMWBWrite = ctrl.memwbWrite;
  assign outIFIDFlush  = ctrl.ifidFlush;
  assign outIDEXFlush  = ctrl.idexFlush;
  assign outEXMEMFlush = ctrl.exmemFlush;
  assign outMEMWBFlush = ctrl.memwbFlush;
  assign outMemTimeout = timeout;
  assign outState      = state;

`ifdef HAZ_STATS_EN
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;
  logic [31:0] waitCnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
      waitCnt  <= '0;
    end else begin
      if (isStall && (stallCnt != '1))
        stallCnt <= stallCnt + 32'd1;
      if (isFlush && (flushCnt != '1))
        flushCnt <= flushCnt + 32'd1;
      if (isFreeze && (waitCnt != '1))
        waitCnt <= waitCnt + 32'd1;
    end
  end

  assign outStallCount = stallCnt;
  assign outFlushCount = flushCnt;
  assign outWaitCount  = waitCnt;
`else
  logic unusedStats;
  assign unusedStats   = &{1'b0, isStall, isFlush};
  assign outStallCount = '0;
  assign outFlushCount = '0;
  assign outWaitCount  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl.
// Statistic expectations follow HAZ_STATS_EN.
module tb_pipe_hazard_ctrl;

`ifdef HAZ_STATS_EN
  localparam int S = 1;
`else
  localparam int S = 0;
`endif

  localparam logic [8:0] E_DRAIN  = 9'b0_0000_1111;
  localparam logic [8:0] E_RUN    = 9'b1_1111_0000;
  localparam logic [8:0] E_FREEZE = 9'b0_0001_0001;
  localparam logic [8:0] E_BRANCH = 9'b1_1111_1100;
  localparam logic [8:0] E_JUMP   = 9'b1_1111_1000;
  localparam logic [8:0] E_LDUSE  = 9'b0_0111_0100;

  logic        Clk;
  logic        Reset;
  logic        inIDEXMemRead;
  logic [4:0]  inIDEXRt;
  logic [4:0]  inIFIDRs;
  logic [4:0]  inIFIDRt;
  logic        inIFIDUsesRt;
  logic        inBranchTaken;
  logic        inJump;
  logic        inMemReq;
  logic        inMemReady;
  logic        outPCWrite;
  logic        outIFIDWrite;
  logic        outIDEXWrite;
  logic        outEXMEMWrite;
  logic        outMEMWBWrite;
  logic        outIFIDFlush;
  logic        outIDEXFlush;
  logic        outEXMEMFlush;
  logic        outMEMWBFlush;
  logic        outMemTimeout;
  logic [1:0]  outState;
  logic [31:0] outStallCount;
  logic [31:0] outFlushCount;
  logic [31:0] outWaitCount;

  int vecCount;
  int errCount;

  pipe_hazard_ctrl dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .inIDEXMemRead (inIDEXMemRead),
    .inIDEXRt      (inIDEXRt),
    .inIFIDRs      (inIFIDRs),
    .inIFIDRt      (inIFIDRt),
    .inIFIDUsesRt  (inIFIDUsesRt),
    .inBranchTaken (inBranchTaken),
    .inJump        (inJump),
    .inMemReq      (inMemReq),
    .inMemReady    (inMemReady),
    .outPCWrite    (outPCWrite),
    .outIFIDWrite  (outIFIDWrite),
    .outIDEXWrite  (outIDEXWrite),
    .outEXMEMWrite (outEXMEMWrite),
    .outMEMWBWrite (outMEMWBWrite),
    .outIFIDFlush  (outIFIDFlush),
    .outIDEXFlush  (outIDEXFlush),
    .outEXMEMFlush (outEXMEMFlush),
    .outMEMWBFlush (outMEMWBFlush),
    .outMemTimeout (outMemTimeout),
    .outState      (outState),
    .outStallCount (outStallCount),
    .outFlushCount (outFlushCount),
    .outWaitCount  (outWaitCount)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [31:0] ctrlVec();
    return {23'd0, outPCWrite, outIFIDWrite,
            outIDEXWrite, outEXMEMWrite,
            outMEMWBWrite, outIFIDFlush,
            outIDEXFlush, outEXMEMFlush,
            outMEMWBFlush};
  endfunction

  task automatic checkVec(input string tag,
                          input logic [31:0] obs,
                          input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic mr,
                       input logic [4:0] rt,
                       input logic [4:0] rs,
                       input logic [4:0] irt,
                       input logic uses,
                       input logic br,
                       input logic jmp,
                       input logic req,
                       input logic rdy);
    inIDEXMemRead = mr;
    inIDEXRt      = rt;
    inIFIDRs      = rs;
    inIFIDRt      = irt;
    inIFIDUsesRt  = uses;
    inBranchTaken = br;
    inJump        = jmp;
    inMemReq      = req;
    inMemReady    = rdy;
    #1;
  endtask

  initial begin
    vecCount = 0;
    errCount = 0;
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    step();
    checkVec("rstCtrl", ctrlVec(), {23'd0, E_DRAIN});
    checkVec("rstState", {30'd0, outState}, 0);
    checkVec("rstTimeout", {31'd0, outMemTimeout}, 0);
    checkVec("rstStall", outStallCount, 0);
    step();
    Reset = 1'b0;
    #1;

    for (int i = 0; i < 4; i++) begin
      checkVec("drainCtrl", ctrlVec(), {23'd0, E_DRAIN});
      checkVec("drainState", {30'd0, outState}, 0);
      step();
    end
    checkVec("runState", {30'd0, outState}, 1);
    checkVec("runCtrl", ctrlVec(), {23'd0, E_RUN});

    drive(1, 8, 8, 10, 1, 0, 0, 0, 0);
    checkVec("luRs", ctrlVec(), {23'd0, E_LDUSE});
    step();
    drive(0, 8, 9, 8, 1, 0, 0, 0, 0);
    checkVec("luDone", ctrlVec(), {23'd0, E_RUN});
    checkVec("stallCnt1", outStallCount, 32'(S));

    drive(1, 8, 3, 8, 1, 0, 0, 0, 0);
    checkVec("luRt", ctrlVec(), {23'd0, E_LDUSE});
    step();
    drive(1, 8, 3, 8, 0, 0, 0, 0, 0);
    checkVec("noUsesRt", ctrlVec(), {23'd0, E_RUN});
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
    checkVec("regZero", ctrlVec(), {23'd0, E_RUN});
    step();

    drive(1, 8, 8, 0, 0, 1, 1, 0, 0);
    checkVec("allThree", ctrlVec(), {23'd0, E_BRANCH});
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkVec("jump", ctrlVec(), {23'd0, E_JUMP});
    step();
    drive(1, 8, 8, 0, 0, 0, 1, 0, 0);
    checkVec("jumpOverLu", ctrlVec(), {23'd0, E_JUMP});
    step();
    checkVec("stallCnt2", outStallCount, 32'(2 * S));
    checkVec("flushCnt3", outFlushCount, 32'(3 * S));

    drive(1, 8, 8, 0, 0, 1, 0, 1, 0);
    checkVec("frz1", ctrlVec(), {23'd0, E_FREEZE});
    checkVec("frz1State", {30'd0, outState}, 1);
    step();
    checkVec("frz2State", {30'd0, outState}, 2);
    checkVec("frz2", ctrlVec(), {23'd0, E_FREEZE});
    step();
    checkVec("frz3", ctrlVec(), {23'd0, E_FREEZE});
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    checkVec("resume", ctrlVec(), {23'd0, E_RUN});
    checkVec("resumeState", {30'd0, outState}, 2);
    step();
    checkVec("backRun", {30'd0, outState}, 1);
    checkVec("noTimeout", {31'd0, outMemTimeout}, 0);
    checkVec("waitCnt3", outWaitCount, 32'(3 * S));
    checkVec("flushKeep", outFlushCount, 32'(3 * S));
    checkVec("stallKeep", outStallCount, 32'(2 * S));

    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 16; k++) begin
      checkVec("toLow", {31'd0, outMemTimeout}, 0);
      step();
    end
    checkVec("toHigh", {31'd0, outMemTimeout}, 1);
    checkVec("toState", {30'd0, outState}, 2);
    for (int k = 0; k < 4; k++) begin
      step();
      checkVec("toSticky", {31'd0, outMemTimeout}, 1);
      checkVec("toFreeze", ctrlVec(), {23'd0, E_FREEZE});
    end
    checkVec("waitCnt23", outWaitCount, 32'(23 * S));

    Reset = 1'b1;
    #1;
    checkVec("rstMidCtrl", ctrlVec(), {23'd0, E_DRAIN});
    step();
    checkVec("rstMidState", {30'd0, outState}, 0);
    checkVec("rstMidTo", {31'd0, outMemTimeout}, 0);
    checkVec("rstMidWait", outWaitCount, 0);
    Reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vecCount, errCount);
    $finish;
  end

endmodule
